// File: rtl/fm_cmn_pkg.sv
// Shared types and constants for the fm_cmn streaming helpers.
// Holds the BRAM read-engine state encoding and the skid buffer sizing.
package fm_cmn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } fm_state_e;

  localparam int unsigned P_BUF_DEPTH = 2;
  localparam int unsigned P_OCC_W     = $clog2(P_BUF_DEPTH + 1);

endpackage

// File: rtl/fm_cmn_skid2.sv
// Two-entry register FIFO used to absorb fixed read latency under backpressure.
// Head and valid come straight from flops; a push with a pop at occupancy 1 lands in the head.
module fm_cmn_skid2
  import fm_cmn_pkg::*;
#(
  parameter int unsigned P_WIDTH = 32
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [P_WIDTH-1:0]   i_data,
  output logic                 o_valid,
  output logic [P_WIDTH-1:0]   o_head,
  output logic [P_OCC_W-1:0]   o_occ
);

  logic [P_WIDTH-1:0] ent0_q, ent0_d;
  logic [P_WIDTH-1:0] ent1_q, ent1_d;
  logic [P_OCC_W-1:0] occ_q, occ_d;
  logic               pop;

  assign pop = i_pop & (occ_q != '0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case ({i_push, pop})
      2'b10: begin
        if (occ_q == '0) begin
          ent0_d = i_data;
        end else begin
          ent1_d = i_data;
        end
        if (occ_q != P_OCC_W'(P_BUF_DEPTH)) begin
          occ_d = occ_q + P_OCC_W'(1);
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - P_OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == P_OCC_W'(1)) begin
          ent0_d = i_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign o_valid = (occ_q != '0);
  assign o_head  = ent0_q;
  assign o_occ   = occ_q;

  // A push into a full buffer without a matching pop loses a word.
  a_no_overflow : assert property (@(posedge clk_core) disable iff (rst_core)
    !(i_push && !pop && (occ_q == P_OCC_W'(P_BUF_DEPTH))));

endmodule

// File: rtl/fm_cmn_bram_rd.sv
// Streams a contiguous, wrapping range out of a no-enable, one-cycle-latency BRAM read port
// as a valid/ack word stream, backed by a two-entry skid buffer.
module fm_cmn_bram_rd
  import fm_cmn_pkg::*;
#(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_RANGE = 2,
  parameter int unsigned P_DEPTH = 1 << P_RANGE
) (
  input  logic               clk_core,
  input  logic               rst_core,
  input  logic               i_start,
  input  logic [P_RANGE-1:0] i_base_addr,
  input  logic [P_RANGE:0]   i_len,
  output logic               o_busy,
  output logic               o_done,
  output logic [P_RANGE-1:0] o_addr,
  input  logic [P_WIDTH-1:0] i_rdata,
  output logic               o_valid,
  output logic [P_WIDTH-1:0] o_data,
  input  logic               i_ack
);

  fm_state_e          state_q, state_d;
  logic [P_RANGE-1:0] base_q, base_d;
  logic [P_RANGE-1:0] addr_q, addr_d;
  logic [P_RANGE-1:0] addr_inc;
  logic [P_RANGE:0]   rem_q, rem_d;
  logic               prime_q, prime_d;
  logic               infl_q, infl_d;
  logic [P_OCC_W-1:0] occ;
  logic [2:0]         load;
  logic               pop;
  logic               issue;

  assign pop  = o_valid & i_ack;
  assign load = 3'(occ) + 3'(infl_q) - 3'(pop);

  assign addr_inc = (addr_q == P_RANGE'(P_DEPTH - 1)) ? '0 : addr_q + P_RANGE'(1);

  // o_addr always presents the next address to read; the RAM samples it every edge, and an
  // issue marks that sample as wanted, so the captured word arrives one edge after the issue.
  assign issue = (state_q == ST_RUN) && !prime_q && (rem_q != '0) && (load < 3'd2);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    prime_d = prime_q;
    infl_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            state_d = ST_RUN;
            base_d  = i_base_addr;
            rem_d   = i_len;
            prime_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (prime_q) begin
          addr_d  = base_q;
          prime_d = 1'b0;
        end else if (issue) begin
          infl_d = 1'b1;
          rem_d  = rem_q - (P_RANGE + 1)'(1);
          if (rem_q == (P_RANGE + 1)'(1)) begin
            state_d = ST_FLUSH;
          end else begin
            addr_d = addr_inc;
          end
        end
      end
      ST_FLUSH: begin
        // Leave once the final word has been captured and is being (or has been) accepted.
        if (!infl_q && ((occ == '0) || ((occ == P_OCC_W'(1)) && pop))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      prime_q <= 1'b0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      prime_q <= prime_d;
      infl_q  <= infl_d;
    end
  end

  fm_cmn_skid2 #(
    .P_WIDTH(P_WIDTH)
  ) u_skid (
    .clk_core(clk_core),
    .rst_core(rst_core),
    .i_push  (infl_q),
    .i_pop   (pop),
    .i_data  (i_rdata),
    .o_valid (o_valid),
    .o_head  (o_data),
    .o_occ   (occ)
  );

  assign o_addr = addr_q;
  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fm_cmn_bram_rd.sv
// Scoreboard bench for fm_cmn_bram_rd: stimulus queues expected words, a negedge monitor
// pops and compares every accepted word and checks that stalled output holds steady.
module tb_fm_cmn_bram_rd;

  localparam int unsigned W = 32;
  localparam int unsigned R = 2;
  localparam int unsigned D = 4;

  localparam logic [W-1:0] A0 = 32'h1111_00A0;
  localparam logic [W-1:0] A1 = 32'h2222_00A1;
  localparam logic [W-1:0] A2 = 32'h3333_00A2;
  localparam logic [W-1:0] A3 = 32'h4444_00A3;

  logic         clk_core = 1'b0;
  logic         rst_core = 1'b1;
  logic         i_start = 1'b0;
  logic         i_ack = 1'b0;
  logic [R-1:0] i_base_addr = '0;
  logic [R:0]   i_len = '0;
  logic         o_busy, o_done, o_valid;
  logic [R-1:0] o_addr;
  logic [W-1:0] i_rdata, o_data;
  logic [W-1:0] ram [D];

  int checks = 0;
  int failures = 0;
  int xfers = 0;
  int dones = 0;
  logic [W-1:0] exp_q [$];
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_data = '0;

  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) i_rdata <= ram[o_addr];

  fm_cmn_bram_rd #(
    .P_WIDTH(W),
    .P_RANGE(R),
    .P_DEPTH(D)
  ) dut (
    .clk_core   (clk_core),
    .rst_core   (rst_core),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_len      (i_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_addr     (o_addr),
    .i_rdata    (i_rdata),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ack      (i_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted words against the scoreboard, stalled words must hold.
  always @(negedge clk_core) begin
    if (rst_core) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_hold_valid", o_valid, 1);
        chk("stall_hold_data", o_data, stall_data);
      end
      if (o_done) dones++;
      if (o_valid && i_ack) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %h expected no word at %0t", o_data, $time);
        end else begin
          chk("word", o_data, exp_q.pop_front());
        end
      end
      stall_q = o_valid && !i_ack;
      stall_data = o_data;
    end
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_start(input logic [R-1:0] b, input logic [R:0] l);
    i_base_addr = b;
    i_len = l;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (o_busy) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int d0;
    int n;
    ram[0] = A0;
    ram[1] = A1;
    ram[2] = A2;
    ram[3] = A3;

    // Reset state
    repeat (3) tick();
    @(negedge clk_core);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    tick();
    rst_core = 1'b0;
    tick();

    // Basic read, ack held high
    i_ack = 1'b1;
    x0 = xfers; d0 = dones;
    exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A2); exp_q.push_back(A3);
    do_start(2'd0, 3'd4);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk_core);
      chk("basic_valid", o_valid, (k >= 3 && k <= 6));
      chk("basic_done", o_done, (k == 7));
      chk("basic_busy", o_busy, (k <= 7));
      if (k >= 1 && k <= 4) chk("basic_addr", o_addr, k - 1);
      tick();
    end
    chk("basic_xfers", xfers - x0, 4);
    chk("basic_dones", dones - d0, 1);
    chk("basic_queue", exp_q.size(), 0);

    // Wrapping range
    x0 = xfers; d0 = dones;
    exp_q.push_back(A3); exp_q.push_back(A0); exp_q.push_back(A1);
    do_start(2'd3, 3'd3);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk_core);
      chk("wrap_valid", o_valid, (k >= 3 && k <= 5));
      chk("wrap_done", o_done, (k == 6));
      if (k >= 1 && k <= 5) chk("wrap_addr", o_addr, (k == 1) ? 3 : (k == 2) ? 0 : 1);
      tick();
    end
    chk("wrap_xfers", xfers - x0, 3);
    chk("wrap_dones", dones - d0, 1);

    // Backpressure: ack low for five cycles after the first valid
    i_ack = 1'b0;
    x0 = xfers; d0 = dones;
    exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A2); exp_q.push_back(A3);
    do_start(2'd0, 3'd4);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk_core);
      if (k >= 3) begin
        chk("bp_valid", o_valid, 1);
        chk("bp_head", o_data, A0);
      end
      chk("bp_addr3_not_reached", (o_addr != 2'd3), 1);
      tick();
    end
    i_ack = 1'b1;
    wait_idle("bp_idle", 40);
    chk("bp_xfers", xfers - x0, 4);
    chk("bp_dones", dones - d0, 1);
    chk("bp_queue", exp_q.size(), 0);
    tick();

    // Alternating ack
    x0 = xfers; d0 = dones;
    exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A2); exp_q.push_back(A3);
    do_start(2'd0, 3'd4);
    n = 0;
    while (o_busy && n < 40) begin
      i_ack = (n % 2 == 0);
      tick();
      n++;
    end
    chk("alt_idle", o_busy, 0);
    chk("alt_xfers", xfers - x0, 4);
    chk("alt_dones", dones - d0, 1);
    chk("alt_queue", exp_q.size(), 0);
    i_ack = 1'b1;
    tick();

    // Zero-length start
    x0 = xfers; d0 = dones;
    do_start(2'd2, 3'd0);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk_core);
      chk("len0_done", o_done, (k == 0));
      chk("len0_busy", o_busy, (k == 0));
      chk("len0_valid", o_valid, 0);
      tick();
    end
    chk("len0_dones", dones - d0, 1);
    chk("len0_xfers", xfers - x0, 0);

    // Start while busy is ignored
    x0 = xfers; d0 = dones;
    exp_q.push_back(A0); exp_q.push_back(A1);
    do_start(2'd0, 3'd2);
    tick();
    i_base_addr = 2'd2;
    i_len = 3'd3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_idle("busy_start_idle", 30);
    repeat (6) tick();
    chk("busy_start_xfers", xfers - x0, 2);
    chk("busy_start_dones", dones - d0, 1);
    chk("busy_start_stays_idle", o_busy, 0);

    // Reset mid-run after two accepted words
    x0 = xfers;
    exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A2); exp_q.push_back(A3);
    do_start(2'd0, 3'd4);
    n = 0;
    while ((xfers - x0) < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_two_words", xfers - x0, 2);
    rst_core = 1'b1;
    exp_q.delete();
    tick();
    @(negedge clk_core);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    tick();
    rst_core = 1'b0;
    d0 = dones;
    repeat (5) tick();
    chk("mid_no_done", dones - d0, 0);
    chk("mid_no_valid", o_valid, 0);
    x0 = xfers; d0 = dones;
    exp_q.push_back(A1); exp_q.push_back(A2);
    do_start(2'd1, 3'd2);
    wait_idle("post_rst_idle", 30);
    chk("post_rst_xfers", xfers - x0, 2);
    chk("post_rst_dones", dones - d0, 1);
    chk("post_rst_queue", exp_q.size(), 0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
